life_vga_renderer: RTL

//  Downstream display stage for the 32x32 Game of Life core. Generates 640x480@60 VGA

---
 rtl/life_vga_renderer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/life_vga_renderer.sv
// Purpose: VGA timing generator that draws a 32x32 Game of Life grid as a block of square cells, framed
//          by a per-frame snapshot of grid_pack. The snapshot and frame_tick both occur at the start of vertical blanking.
// Latency: the registered outputs show pixel (hcnt,vcnt) for one pixel period, starting at the pix_ce that advances past it.
// Backpressure: none; the block free-runs and grid_pack is sampled only at the snapshot point.
// Ports: clk, resetn (sync, active-low), grid_pack[1023:0] (bit row*32+col, row 0 at bottom),
//        hsync/vsync (active-low), de, rgb[11:0] {R,G,B} (zero outside de), frame_tick (1-clk pulse).
module life_vga_renderer #(
    parameter int          PIX_DIV    = 2,
    parameter int          CELL_SHIFT = 3,
    parameter int          X0         = 192,
    parameter int          Y0         = 112,
    parameter logic [11:0] ALIVE_RGB  = 12'hFFF,
    parameter logic [11:0] DEAD_RGB   = 12'h111,
    parameter int          H_VIS      = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_VIS      = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [1023:0] grid_pack,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [11:0]   rgb,
    output logic          frame_tick
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam int WIN = 32 << CELL_SHIFT;

    localparam logic [9:0]  H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0]  HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0]  H_VIS_L  = 10'(H_VIS);
    localparam logic [9:0]  V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]  VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0]  V_VIS_L  = 10'(V_VIS);
    localparam logic [9:0]  V_SNAP   = 10'(V_VIS - 1);
    localparam logic [9:0]  WX_LO    = 10'(X0);
    localparam logic [9:0]  WY_LO    = 10'(Y0);
    // Window ends are exclusive and kept one bit wider so X0+WIN may reach 1024.
    localparam logic [10:0] WX_HI    = 11'(X0 + WIN);
    localparam logic [10:0] WY_HI    = 11'(Y0 + WIN);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hcnt_q, hcnt_d;
    logic [9:0]       vcnt_q, vcnt_d;
    logic [1023:0]    snap_q, snap_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             tick_q, tick_d;

    logic             pix_ce;
    logic             line_end;
    logic             snap_pt;
    logic             visible;
    logic             in_win;
    logic [9:0]       hoff, voff;
    logic [9:0]       hcell, vcell;
    logic [9:0]       cell_idx;
    logic             cell_on;
    logic             unused_cell_hi;

    // Only the low 5 bits of the cell coordinates can be non-zero inside the window.
    assign unused_cell_hi = ^{hcell[9:5], vcell[9:5]};

    always_comb begin
        pix_ce   = (div_q == DIV_LAST);
        div_d    = pix_ce ? '0 : div_q + DIV_W'(1);
        line_end = (hcnt_q == H_LAST);
        snap_pt  = pix_ce && line_end && (vcnt_q == V_SNAP);
        visible  = (hcnt_q < H_VIS_L) && (vcnt_q < V_VIS_L);
        in_win   = (hcnt_q >= WX_LO) && ({1'b0, hcnt_q} < WX_HI) &&
                   (vcnt_q >= WY_LO) && ({1'b0, vcnt_q} < WY_HI);

        // Offsets are only meaningful once the window test has passed.
        hoff     = '0;
        voff     = '0;
        if (in_win) begin
            hoff = hcnt_q - WX_LO;
            voff = vcnt_q - WY_LO;
        end
        hcell    = hoff >> CELL_SHIFT;
        vcell    = voff >> CELL_SHIFT;
        // Screen y grows downward while row 0 is the bottom row, so flip the row.
        cell_idx = {5'd31 - vcell[4:0], hcell[4:0]};
        cell_on  = snap_q[cell_idx];

        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        de_d     = de_q;
        rgb_d    = rgb_q;
        snap_d   = snap_pt ? grid_pack : snap_q;
        tick_d   = snap_pt;

        if (pix_ce) begin
            if (line_end) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
            hsync_d = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
            vsync_d = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
            de_d    = visible;
            rgb_d   = (visible && in_win) ? (cell_on ? ALIVE_RGB : DEAD_RGB) : 12'h000;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_q   <= '0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            snap_q  <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            rgb_q   <= 12'h000;
            tick_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            snap_q  <= snap_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
            tick_q  <= tick_d;
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign de         = de_q;
    assign rgb        = rgb_q;
    assign frame_tick = tick_q;

endmodule
